// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I width codes, FSM encoding, decode helpers.
// Optional feature macro used by the unit: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   function automatic logic f3_illegal(input logic wr, input logic [2:0] f3);
      if (wr) return (f3 > F3_W);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   // Low two bits of funct3 give the access size for both signed and unsigned forms.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return (lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] align_down(input logic [2:0] f3, input logic [31:0] a);
      case (f3[1:0])
         2'b01:   return {a[31:1], 1'b0};
         2'b10:   return {a[31:2], 2'b00};
         default: return a;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load lane extract with sign/zero extension, and
// store merge of byte/half data into the previously read word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_word_o
);

   logic [31:0] lane;
   assign lane = word_i >> {addr_lo_i, 3'b000};

   always_comb begin
      load_data_o = word_i;
      case (funct3_i)
         F3_B:    load_data_o = {{24{lane[7]}}, lane[7:0]};
         F3_BU:   load_data_o = {24'h0, lane[7:0]};
         F3_H:    load_data_o = {{16{lane[15]}}, lane[15:0]};
         F3_HU:   load_data_o = {16'h0, lane[15:0]};
         default: load_data_o = word_i;
      endcase
   end

   always_comb begin
      store_word_o = word_i;
      case (funct3_i)
         F3_B:    store_word_o[8*addr_lo_i +: 8]      = wdata_i[7:0];
         F3_H:    store_word_o[16*addr_lo_i[1] +: 16] = wdata_i[15:0];
         F3_W:    store_word_o = wdata_i;
         default: store_word_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit: IDLE -> RD -> WR -> RESP, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning down.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        resp_err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   logic [1:0]  state_q, state_d;
   logic        write_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] word_q;
   logic        err_q;

   logic        accept;
   logic        acc_err;
   logic [31:0] acc_addr;
   logic [31:0] load_data;
   logic [31:0] store_word;

   assign accept = req_valid && (state_q == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign acc_err  = f3_illegal(req_write, funct3) || misaligned(funct3, addr[1:0]);
   assign acc_addr = addr;
`else
   assign acc_err  = f3_illegal(req_write, funct3);
   assign acc_addr = align_down(funct3, addr);
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (acc_err)                        state_d = ST_RESP;
               else if (req_write && funct3 == F3_W) state_d = ST_WR;
               else                                state_d = ST_RD;
            end
         end
         ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
         ST_WR:   state_d = ST_RESP;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         word_q  <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            write_q <= req_write;
            f3_q    <= funct3;
            addr_q  <= acc_addr;
            wdata_q <= wdata;
            err_q   <= acc_err;
         end
         if (state_q == ST_RD) word_q <= mem_rdata;
      end
   end

   lsu_align u_align (
      .word_i       (word_q),
      .addr_lo_i    (addr_q[1:0]),
      .funct3_i     (f3_q),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .store_word_o (store_word)
   );

   // Memory-side outputs are gated by state so IDLE/RESP (and reset) present all zeros.
   assign req_ready  = (state_q == ST_IDLE);
   assign MemRead    = (state_q == ST_RD);
   assign MemWrite   = (state_q == ST_WR);
   assign mem_addr   = (MemRead || MemWrite) ? {addr_q[31:2], 2'b00} : 32'h0;
   assign mem_wdata  = MemWrite ? store_word : 32'h0;
   assign resp_valid = (state_q == ST_RESP);
   assign rdata      = (resp_valid && !write_q && !err_q) ? load_data : 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
   assign resp_err = resp_valid && err_q;
`else
   assign resp_err = 1'b0;
`endif

endmodule
